adc_req_arbiter: RTL and testbench
==================================

ADC_REQ_ARBITER -- requirements
Module: adc_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the ADC controller.
REQ-002 Parameter DW, default 10: conversion result width.
REQ-003 Parameter CHW, default 3: channel-select width.
REQ-004 Parameter TMO, default 255: conversion timeout in clk cycles, 8 bits.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-006 Port clk, input, 1: sole clock; all logic rising-edge.
REQ-007 Port rst_n, input, 1: asynchronous assert, active-low reset.
REQ-008 Port en, input, 1: enables new grants.
REQ-009 Port req, input, NREQ: level request per requester.
REQ-010 Port req_ch, input, NREQ*CHW: channel per requester; requester i uses bits [i*CHW +: CHW].
REQ-011 Port gnt, output, NREQ: one-hot, 1-cycle acceptance pulse.
REQ-012 Port rsp_valid, output, NREQ: one-hot, 1-cycle result pulse to the owner.
REQ-013 Port rsp_data, output, DW: last result, shared by all requesters.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port adc_soc, output, 1: start-of-conversion pulse to the ADC controller.
REQ-016 Port adc_ch_sel, output, CHW: channel to the ADC controller.
REQ-017 Port adc_eoc, input, 1: end-of-conversion level from the ADC controller.
REQ-018 Port adc_data, input, DW: conversion result.
REQ-019 Port timeout_err, output, 1: 1-cycle pulse on conversion timeout.

Function
REQ-020 The FSM SHALL have four states: IDLE, START, CONV, DONE.
REQ-021 IDLE, en=1 and req!=0: pick the round-robin winner w, starting at the requester after the last granted one.
  - Latch w and its channel.
  - Pulse gnt[w] in the next cycle.
  - Go to START.
REQ-022 START: drive adc_ch_sel with the latched channel and adc_soc=1 for exactly 1 cycle, then go to CONV.
REQ-023 CONV: register adc_eoc and wait for its rising edge (eoc_q=0, adc_eoc=1).
  - A stale high eoc at CONV entry SHALL NOT complete the conversion.
REQ-024 On the eoc rising edge:
  - Capture adc_data into rsp_data.
  - Go to DONE.
REQ-025 DONE: pulse rsp_valid[owner] for 1 cycle, then go to IDLE.
  - A new grant is possible in the cycle after DONE.
REQ-026 rsp_data SHALL hold its value until the next capture.
REQ-027 adc_ch_sel SHALL hold the latched channel from START until the next grant.
REQ-028 Latency: req seen in IDLE at cycle 0 -> gnt at cycle 1 -> adc_soc at cycle 2 -> rsp_valid 2 cycles after the eoc rising edge.
REQ-029 A requester that deasserts req after gnt SHALL still receive its rsp_valid.
REQ-030 A request dropped before the grant is not served.
REQ-031 en deasserted mid-operation: the conversion in flight completes normally; no grant is issued while en=0.
REQ-032 With a single active requester, it SHALL be granted back-to-back with no fairness gap.
REQ-033 req_ch changes after the grant SHALL NOT affect the conversion in flight.

Reset
REQ-034 While rst_n=0:
  - state=IDLE.
  - gnt, rsp_valid, adc_soc, busy and timeout_err are 0.
  - rsp_data=0 and adc_ch_sel=0.
  - The round-robin pointer points to NREQ-1, so requester 0 has first priority.
REQ-035 Reset asserted mid-conversion SHALL abort it with no rsp_valid issued.

Configuration
REQ-036 The macro ADC_REQ_ARBITER_TIMEOUT_EN SHALL control the timeout feature.
REQ-037 With ADC_REQ_ARBITER_TIMEOUT_EN defined:
  - An 8-bit counter clears on CONV entry and counts each CONV cycle.
  - If it reaches TMO without an eoc rising edge, rsp_data is set to all ones and timeout_err pulses in the same cycle as entering DONE.
  - DONE then pulses rsp_valid[owner] as normal.
REQ-038 Without ADC_REQ_ARBITER_TIMEOUT_EN:
  - CONV waits indefinitely.
  - timeout_err is tied to 0.
  - No timeout counter is synthesised.

Structure
REQ-039 A shared package file SHALL hold:
  - the state encoding constants (IDLE=0, START=1, CONV=2, DONE=3);
  - the default widths DW, CHW and NREQ.
REQ-040 Round-robin selection SHALL be one sub-module, rr_pick: inputs request vector and last-grant pointer; outputs one-hot winner and a valid flag; purely combinational.

Verification
REQ-041 Single request:
  - Stimulus: req=0001, req_ch[0]=5; ADC model raises eoc 20 cycles after soc with data 0x2A5.
  - Response: gnt=0001 at +1; adc_ch_sel=5 and adc_soc at +2; rsp_valid=0001 and rsp_data=0x2A5.
REQ-042 Fairness:
  - Stimulus: req=1111 held for 8 conversions.
  - Response: grant order 0,1,2,3,0,1,2,3; each rsp_valid goes to the matching owner.
REQ-043 Stale eoc:
  - Stimulus: adc_eoc held high before soc, then low for 3 cycles, then high.
  - Response: data is captured only on the second edge.
REQ-044 Enable gating:
  - Stimulus: en=0 during CONV with req=0110.
  - Response: the current rsp_valid is issued; no further gnt until en=1.
REQ-045 Timeout, with ADC_REQ_ARBITER_TIMEOUT_EN:
  - Stimulus: no eoc after soc.
  - Response: after 255 CONV cycles, timeout_err pulses, rsp_data=0x3FF and rsp_valid goes to the owner.
REQ-046 Mid-conversion reset:
  - Stimulus: rst_n=0 in CONV.
  - Response: all outputs are 0 and no rsp_valid; after release, req=1000 is granted as the first grant.

Source files
------------

// File: rtl/adc_req_arbiter_pkg.sv
// rtl/adc_req_arbiter_pkg.sv - shared state encoding and default widths for the ADC request arbiter
// Holds the FSM state type and the default NREQ/DW/CHW/TMO values used by
// adc_req_arbiter and rr_pick.
package adc_req_arbiter_pkg;

    localparam int         ARB_NREQ = 4;
    localparam int         ARB_DW   = 10;
    localparam int         ARB_CHW  = 3;
    localparam logic [7:0] ARB_TMO  = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
// Ports:
//   req       [N-1:0]  request vector
//   last_ptr  [PW-1:0] index of the last granted requester
//   win_oh    [N-1:0]  one-hot winner (zero when no request)
//   win_valid          at least one request present
module rr_pick
    import adc_req_arbiter_pkg::*;
#(
    parameter int N  = ARB_NREQ,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last_ptr,
    output logic [N-1:0]  win_oh,
    output logic          win_valid
);

    logic found;

    // First pass looks strictly above the last grant, second pass wraps to the
    // bottom; the last granted requester itself is reached last, so a lone
    // requester still wins every time.
    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(last_ptr))) begin
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign win_valid = |req;

endmodule

// File: rtl/adc_req_arbiter.sv
// rtl/adc_req_arbiter.sv - round-robin arbiter sharing one ADC controller among NREQ requesters
// Optional feature: define ADC_REQ_ARBITER_TIMEOUT_EN to abort conversions after TMO cycles.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   en                      allows new grants
//   req, req_ch             per-requester request level and channel
//   gnt                     one-hot acceptance pulse
//   rsp_valid, rsp_data     one-hot result pulse to the owner, shared result
//   busy                    FSM not in IDLE
//   adc_soc, adc_ch_sel     start-of-conversion pulse and channel to the ADC
//   adc_eoc, adc_data       end-of-conversion level and result from the ADC
//   timeout_err             pulse when a conversion times out
module adc_req_arbiter
    import adc_req_arbiter_pkg::*;
#(
    parameter int         NREQ = ARB_NREQ,
    parameter int         DW   = ARB_DW,
    parameter int         CHW  = ARB_CHW,
    parameter logic [7:0] TMO  = ARB_TMO
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*CHW-1:0] req_ch,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                busy,
    output logic                adc_soc,
    output logic [CHW-1:0]      adc_ch_sel,
    input  logic                adc_eoc,
    input  logic [DW-1:0]       adc_data,
    output logic                timeout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            soc_q, soc_d;
    logic            eoc_q, eoc_d;

    logic [NREQ-1:0] win_oh;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [CHW-1:0]  win_ch;

`ifdef ADC_REQ_ARBITER_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_err_q, tmo_err_d;
`endif

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_pick (
        .req       (req),
        .last_ptr  (ptr_q),
        .win_oh    (win_oh),
        .win_valid (win_valid)
    );

    // Winner index and its channel, taken from the one-hot winner.
    always_comb begin
        win_idx = '0;
        win_ch  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx = PW'(i);
            end
            win_ch = win_ch | (req_ch[i*CHW +: CHW] & {CHW{win_oh[i]}});
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        soc_d       = 1'b0;
        eoc_d       = adc_eoc;
`ifdef ADC_REQ_ARBITER_TIMEOUT_EN
        cnt_d       = cnt_q;
        tmo_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (en && win_valid) begin
                    owner_d = win_oh;
                    ptr_d   = win_idx;
                    ch_d    = win_ch;
                    gnt_d   = win_oh;
                    state_d = START;
                end
            end
            START: begin
                soc_d   = 1'b1;
                state_d = CONV;
`ifdef ADC_REQ_ARBITER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            CONV: begin
                // eoc_q holds last cycle's level, so an eoc already high on
                // entry is not an edge.
                if (adc_eoc && !eoc_q) begin
                    rsp_data_d = adc_data;
                    state_d    = DONE;
                end
`ifdef ADC_REQ_ARBITER_TIMEOUT_EN
                else if (cnt_q == TMO - 8'd1) begin
                    rsp_data_d = '1;
                    tmo_err_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                rsp_valid_d = owner_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= PW'(NREQ - 1);
            ch_q        <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            soc_q       <= 1'b0;
            eoc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            soc_q       <= soc_d;
            eoc_q       <= eoc_d;
        end
    end

`ifdef ADC_REQ_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic tmo_unused;
    assign tmo_unused  = ^TMO;
    assign timeout_err = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != IDLE);
    assign adc_soc    = soc_q;
    assign adc_ch_sel = ch_q;

endmodule

// File: tb/tb_adc_req_arbiter.sv
// tb/tb_adc_req_arbiter.sv - self-checking bench for adc_req_arbiter
module tb_adc_req_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [11:0] req_ch;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [9:0]  rsp_data;
    logic        busy;
    logic        adc_soc;
    logic [2:0]  adc_ch_sel;
    logic        adc_eoc;
    logic [9:0]  adc_data;
    logic        timeout_err;

    adc_req_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .req_ch      (req_ch),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .adc_soc     (adc_soc),
        .adc_ch_sel  (adc_ch_sel),
        .adc_eoc     (adc_eoc),
        .adc_data    (adc_data),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] owner;
        logic [9:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] req_ch;
        int          eoc_dly;
        logic [9:0]  data;
        int          exp_w;
        logic [2:0]  exp_ch;
        bit          drop;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       vecs[12];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid != 4'b0000) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid 0x%0h, expected none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_owner", 32'(rsp_valid), 32'(mon_e.owner));
                chk("sb_data", 32'(rsp_data), 32'(mon_e.data));
            end
        end
`ifndef ADC_REQ_ARBITER_TIMEOUT_EN
        chk("tmo_tied", 32'(timeout_err), 32'd0);
`endif
    end

    task automatic run_conv(input logic [3:0] r, input logic [11:0] rc, input int dly,
                            input logic [9:0] d, input int w, input logic [2:0] ch, input bit drop);
        chk("busy_idle", 32'(busy), 32'd0);
        req    = r;
        req_ch = rc;
        en     = 1'b1;
        sb.push_back('{owner: 4'(1 << w), data: d});
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(1 << w));
        if (drop) begin
            req    = 4'b0000;
            req_ch = 12'hFFF;
        end
        @(negedge clk);
        chk("soc", 32'(adc_soc), 32'd1);
        chk("ch_sel", 32'(adc_ch_sel), 32'(ch));
        repeat (dly) @(negedge clk);
        chk("soc_once", 32'(adc_soc), 32'd0);
        chk("ch_hold", 32'(adc_ch_sel), 32'(ch));
        chk("busy_conv", 32'(busy), 32'd1);
        chk("rsp_hold", 32'(rsp_data), 32'(last_data));
        adc_eoc  = 1'b1;
        adc_data = d;
        @(negedge clk);
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_lat", 32'(rsp_valid), 32'(1 << w));
        adc_eoc   = 1'b0;
        adc_data  = 10'h3C3;
        last_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // fairness after reset: 0,1,2,3,0,1,2,3 with ch0=6, ch1=1, ch2=2, ch3=3
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{4'b1111, 12'h68E, 3 + i, 10'(32'h100 + i * 37), i % 4,
                        3'((i % 4 == 0) ? 6 : i % 4), 1'b0};
        end
        vecs[8]  = '{4'b0001, 12'h005, 20, 10'h2A5, 0, 3'd5, 1'b0};
        vecs[9]  = '{4'b0100, 12'h100, 6,  10'h1B4, 2, 3'd4, 1'b1};
        vecs[10] = '{4'b0010, 12'h038, 2,  10'h3E1, 1, 3'd7, 1'b0};
        vecs[11] = '{4'b0010, 12'h038, 1,  10'h01C, 1, 3'd7, 1'b0};

        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 4'b0000;
        req_ch   = '0;
        adc_eoc  = 1'b0;
        adc_data = '0;
        repeat (2) @(negedge clk);
        req = 4'b1111;
        en  = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_soc", 32'(adc_soc), 32'd0);
        chk("rst_ch_sel", 32'(adc_ch_sel), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        req   = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].req, vecs[i].req_ch, vecs[i].eoc_dly, vecs[i].data,
                     vecs[i].exp_w, vecs[i].exp_ch, vecs[i].drop);
        end
        req = 4'b0000;

        // stale eoc: high before soc must not complete; only the later edge does
        adc_eoc  = 1'b1;
        adc_data = 10'h0AA;
        req      = 4'b0001;
        req_ch   = 12'h002;
        sb.push_back('{owner: 4'b0001, data: 10'h155});
        @(negedge clk);
        chk("stale_gnt", 32'(gnt), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("stale_soc", 32'(adc_soc), 32'd1);
        chk("stale_ch", 32'(adc_ch_sel), 32'd2);
        repeat (4) @(negedge clk);
        chk("stale_busy", 32'(busy), 32'd1);
        chk("stale_nocap", 32'(rsp_data), 32'(last_data));
        adc_eoc = 1'b0;
        repeat (3) @(negedge clk);
        adc_eoc  = 1'b1;
        adc_data = 10'h155;
        @(negedge clk);
        chk("stale_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("stale_rsp", 32'(rsp_valid), 32'd1);
        adc_eoc   = 1'b0;
        last_data = 10'h155;

        // enable gating: en drops during CONV, conversion still completes
        req    = 4'b0110;
        req_ch = 12'h118;
        sb.push_back('{owner: 4'b0010, data: 10'h2C1});
        @(negedge clk);
        chk("en_gnt", 32'(gnt), 32'b0010);
        @(negedge clk);
        chk("en_soc", 32'(adc_soc), 32'd1);
        en = 1'b0;
        repeat (5) @(negedge clk);
        adc_eoc  = 1'b1;
        adc_data = 10'h2C1;
        repeat (2) @(negedge clk);
        chk("en_rsp", 32'(rsp_valid), 32'b0010);
        adc_eoc   = 1'b0;
        last_data = 10'h2C1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("en_nognt", 32'(gnt), 32'd0);
            chk("en_idle", 32'(busy), 32'd0);
        end
        run_conv(4'b0110, 12'h118, 4, 10'h0F0, 2, 3'd4, 1'b0);
        req = 4'b0000;

        // reset in CONV aborts without rsp_valid; pointer returns to NREQ-1
        req    = 4'b0001;
        req_ch = 12'h001;
        @(negedge clk);
        chk("mrst_gnt", 32'(gnt), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("mrst_soc", 32'(adc_soc), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_gnt0", 32'(gnt), 32'd0);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_soc0", 32'(adc_soc), 32'd0);
        chk("mrst_ch_sel", 32'(adc_ch_sel), 32'd0);
        adc_eoc  = 1'b1;
        adc_data = 10'h111;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        adc_eoc = 1'b0;
        repeat (4) @(negedge clk);
        chk("mrst_after_busy", 32'(busy), 32'd0);
        last_data = '0;
        run_conv(4'b1000, 12'hE00, 5, 10'h0C7, 3, 3'd7, 1'b0);
        req = 4'b0000;

`ifdef ADC_REQ_ARBITER_TIMEOUT_EN
        begin
            int cyc;
            req    = 4'b0100;
            req_ch = 12'h0C0;
            sb.push_back('{owner: 4'b0100, data: 10'h3FF});
            @(negedge clk);
            chk("tmo_gnt", 32'(gnt), 32'b0100);
            req = 4'b0000;
            @(negedge clk);
            chk("tmo_soc", 32'(adc_soc), 32'd1);
            cyc = 0;
            while (timeout_err !== 1'b1 && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            chk("tmo_cycles", 32'(cyc), 32'd255);
            chk("tmo_data", 32'(rsp_data), 32'h3FF);
            @(negedge clk);
            chk("tmo_rsp", 32'(rsp_valid), 32'b0100);
            chk("tmo_pulse", 32'(timeout_err), 32'd0);
        end
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
